// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RISC-V
// funct3 access encodings and the access legality/misalignment predicates.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        RESP0,
        REQ1,
        RESP1,
        DONE
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;

    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;
    localparam logic [2:0] F3_SD  = 3'd3;

    // An access spills into the next beat when its last byte lies past the beat end.
    function automatic logic is_misaligned(input logic [2:0] offset,
                                           input logic [1:0] size_log2,
                                           input int beat_bytes);
        return (int'(offset) + (1 << size_log2)) > beat_bytes;
    endfunction

    function automatic logic is_legal(input logic is_store,
                                      input logic [2:0] funct3,
                                      input int data_width);
        logic wide;
        wide = (data_width == 64);
        if (is_store)
            return (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW) ||
                   (wide && (funct3 == F3_SD));
        return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
               (funct3 == F3_LBU) || (funct3 == F3_LHU) ||
               (wide && ((funct3 == F3_LD) || (funct3 == F3_LWU)));
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane datapath: places store data/mask into a beat and extracts,
// merges and extends load data from one or two beats (little-endian).
module load_store_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int BEAT_BYTES = DATA_WIDTH / 8,
    localparam int OFF_W = $clog2(BEAT_BYTES)
) (
    input  logic [OFF_W-1:0]      offset,
    input  logic [2:0]            funct3,
    input  logic                  beat_sel,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [DATA_WIDTH-1:0] low_data,
    input  logic [DATA_WIDTH-1:0] high_data,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic [BEAT_BYTES-1:0] write_mask,
    output logic [DATA_WIDTH-1:0] load_result
);

    logic [BEAT_BYTES-1:0]   size_mask;
    logic [DATA_WIDTH-1:0]   byte_bits;
    logic [2*DATA_WIDTH-1:0] wide_store;
    logic [2*DATA_WIDTH-1:0] wide_load;
    logic [2*BEAT_BYTES-1:0] wide_mask;
    logic [DATA_WIDTH-1:0]   raw;
    logic                    sign_bit;

    // Shift into a double-width window so the spill into beat 1 falls out naturally.
    always_comb begin
        size_mask = '0;
        byte_bits = '0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            size_mask[i]       = (i < (1 << funct3[1:0]));
            byte_bits[8*i +: 8] = {8{size_mask[i]}};
        end
        wide_store = {{DATA_WIDTH{1'b0}}, store_data & byte_bits} << {offset, 3'b000};
        wide_mask  = {{BEAT_BYTES{1'b0}}, size_mask} << offset;
        write_data = beat_sel ? wide_store[2*DATA_WIDTH-1:DATA_WIDTH] : wide_store[DATA_WIDTH-1:0];
        write_mask = beat_sel ? wide_mask[2*BEAT_BYTES-1:BEAT_BYTES] : wide_mask[BEAT_BYTES-1:0];
    end

    always_comb begin
        wide_load = {high_data, low_data} >> {offset, 3'b000};
        raw       = wide_load[DATA_WIDTH-1:0] & byte_bits;
        case (funct3[1:0])
            2'd0:    sign_bit = raw[7];
            2'd1:    sign_bit = raw[15];
            2'd2:    sign_bit = raw[31];
            default: sign_bit = 1'b0;
        endcase
        if ((funct3 == F3_LB || funct3 == F3_LH || funct3 == F3_LW) && sign_bit)
            load_result = raw | ~byte_bits;
        else
            load_result = raw;
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding memory access FSM with fault reporting.
// Define MISALIGNED_SPLIT_EN to split misaligned accesses into two beats.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                      clock,
    input  logic                      clear,
    input  logic                      enable,
    input  logic                      is_store,
    input  logic [2:0]                funct3,
    input  logic [ADDRESS_WIDTH-1:0]  source,
    input  logic [DATA_WIDTH-1:0]     store_data,
    output logic [DATA_WIDTH-1:0]     new_rd,
    output logic                      finished,
    output logic                      error,
    output logic                      hart_to_memory_controller_valid,
    input  logic                      hart_to_memory_controller_ready,
    output logic [ADDRESS_WIDTH-1:0]  hart_to_memory_controller_address,
    output logic                      hart_to_memory_controller_write,
    output logic [DATA_WIDTH-1:0]     hart_to_memory_controller_write_data,
    output logic [DATA_WIDTH/8-1:0]   hart_to_memory_controller_write_mask,
    input  logic                      memory_controller_to_hart_valid,
    input  logic                      memory_controller_to_hart_error,
    input  logic [DATA_WIDTH-1:0]     memory_controller_to_hart_read_data,
    output logic                      memory_controller_to_hart_ready
);

    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int OFF_W      = $clog2(BEAT_BYTES);
`ifdef MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    lsu_state_e state, next_state;
    logic                     is_store_q, split_q, error_q, fault, cur_is_store;
    logic [2:0]               funct3_q;
    logic [ADDRESS_WIDTH-1:0] source_q, beat_base;
    logic [DATA_WIDTH-1:0]    store_data_q, beat0_q;
    logic [DATA_WIDTH-1:0]    align_wdata, load_low, load_high, load_result;
    logic [BEAT_BYTES-1:0]    align_mask;
    logic                     in_misaligned, in_legal, second_beat;

    assign in_misaligned = is_misaligned(3'(source[OFF_W-1:0]), funct3[1:0], BEAT_BYTES);
    assign in_legal      = is_legal(is_store, funct3, DATA_WIDTH);
    assign cur_is_store  = (state == IDLE) ? is_store : is_store_q;
    assign second_beat   = (state == REQ1);

    always_comb begin
        next_state = state;
        fault      = 1'b0;
        case (state)
            IDLE:
                if (enable) begin
                    if (!in_legal || (in_misaligned && !SPLIT_EN)) begin
                        next_state = DONE;
                        fault      = 1'b1;
                    end else begin
                        next_state = REQ0;
                    end
                end
            REQ0:
                if (hart_to_memory_controller_ready) next_state = RESP0;
            RESP0:
                if (memory_controller_to_hart_valid) begin
                    fault      = memory_controller_to_hart_error;
                    next_state = (split_q && !memory_controller_to_hart_error) ? REQ1 : DONE;
                end
            REQ1:
                if (hart_to_memory_controller_ready) next_state = RESP1;
            RESP1:
                if (memory_controller_to_hart_valid) begin
                    fault      = memory_controller_to_hart_error;
                    next_state = DONE;
                end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // new_rd and error are settled on the edge that enters DONE.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state        <= IDLE;
            is_store_q   <= 1'b0;
            funct3_q     <= '0;
            source_q     <= '0;
            store_data_q <= '0;
            split_q      <= 1'b0;
            beat0_q      <= '0;
            error_q      <= 1'b0;
            new_rd       <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && enable) begin
                is_store_q   <= is_store;
                funct3_q     <= funct3;
                source_q     <= source;
                store_data_q <= store_data;
                split_q      <= SPLIT_EN && in_misaligned;
            end
            if (state == RESP0 && memory_controller_to_hart_valid)
                beat0_q <= memory_controller_to_hart_read_data;
            if (next_state == DONE && state != DONE) begin
                error_q <= fault;
                if (!cur_is_store)
                    new_rd <= fault ? '0 : load_result;
            end
        end
    end

    assign load_low  = split_q ? beat0_q : memory_controller_to_hart_read_data;
    assign load_high = split_q ? memory_controller_to_hart_read_data : '0;

    load_store_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .offset      (source_q[OFF_W-1:0]),
        .funct3      (funct3_q),
        .beat_sel    (second_beat),
        .store_data  (store_data_q),
        .low_data    (load_low),
        .high_data   (load_high),
        .write_data  (align_wdata),
        .write_mask  (align_mask),
        .load_result (load_result)
    );

    assign beat_base = {source_q[ADDRESS_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

    assign finished = (state == DONE);
    assign error    = (state == DONE) && error_q;

    assign hart_to_memory_controller_valid      = (state == REQ0) || (state == REQ1);
    assign hart_to_memory_controller_address    = beat_base + (second_beat ? ADDRESS_WIDTH'(BEAT_BYTES) : '0);
    assign hart_to_memory_controller_write      = is_store_q;
    assign hart_to_memory_controller_write_data = is_store_q ? align_wdata : '0;
    assign hart_to_memory_controller_write_mask = is_store_q ? align_mask : '0;
    assign memory_controller_to_hart_ready      = (state == RESP0) || (state == RESP1);

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-array memory responder plus a
// byte-level reference model; honours MISALIGNED_SPLIT_EN like the design.
module tb_load_store_unit;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clock = 1'b0;
    logic          clear = 1'b1;
    logic          enable = 1'b0;
    logic          is_store = 1'b0;
    logic [2:0]    funct3 = '0;
    logic [AW-1:0] source = '0;
    logic [DW-1:0] store_data = '0;
    logic [DW-1:0] new_rd;
    logic          finished, error;
    logic          req_valid, req_write;
    logic          req_ready = 1'b0;
    logic [AW-1:0] req_address;
    logic [DW-1:0] req_wdata;
    logic [3:0]    req_mask;
    logic          resp_valid = 1'b0;
    logic          resp_error = 1'b0;
    logic [DW-1:0] resp_data = '0;
    logic          resp_ready;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0]  mem     [0:511];
    logic [7:0]  ref_mem [0:511];
    logic [31:0] last_rd = '0;

    int          force_stall = -1;
    int          force_delay = -1;
    bit          inject_err = 1'b0;
    logic [31:0] exp_base = '0;
    logic        exp_store = 1'b0;
    int          beat_idx = 0;
    int          req_count = 0;
    logic [31:0] cap_addr, cap_data;
    logic [3:0]  cap_mask;

    load_store_unit #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clock                                (clock),
        .clear                                (clear),
        .enable                               (enable),
        .is_store                             (is_store),
        .funct3                               (funct3),
        .source                               (source),
        .store_data                           (store_data),
        .new_rd                               (new_rd),
        .finished                             (finished),
        .error                                (error),
        .hart_to_memory_controller_valid      (req_valid),
        .hart_to_memory_controller_ready      (req_ready),
        .hart_to_memory_controller_address    (req_address),
        .hart_to_memory_controller_write      (req_write),
        .hart_to_memory_controller_write_data (req_wdata),
        .hart_to_memory_controller_write_mask (req_mask),
        .memory_controller_to_hart_valid      (resp_valid),
        .memory_controller_to_hart_error      (resp_error),
        .memory_controller_to_hart_read_data  (resp_data),
        .memory_controller_to_hart_ready      (resp_ready)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic setWord(input int addr, input logic [31:0] value);
        for (int i = 0; i < 4; i++) begin
            mem[(addr + i) % 512]     = value[8*i +: 8];
            ref_mem[(addr + i) % 512] = value[8*i +: 8];
        end
    endtask

    // Memory controller model: checks and serves one beat per request.
    always begin : responder
        logic [31:0] a, d;
        logic [3:0]  m;
        logic        w, err;
        int          beat, stall, dly;
        @(negedge clock);
        if (req_valid === 1'b1 && !clear) begin
            beat = beat_idx;
            beat_idx++;
            a = req_address; d = req_wdata; m = req_mask; w = req_write;
            if (beat == 0) begin cap_addr = a; cap_data = d; cap_mask = m; end
            checkOutput("req_addr", a, exp_base + 32'(4 * beat));
            checkOutput("req_write", w, exp_store);
            if (!w) begin
                checkOutput("load_wdata", d, 0);
                checkOutput("load_mask", m, 0);
            end
            stall = (force_stall >= 0) ? force_stall : $urandom_range(0, 2);
            for (int i = 0; i < stall; i++) begin
                req_ready = 1'b0;
                @(negedge clock);
                checkOutput("hold_valid", req_valid, 1);
                checkOutput("hold_addr", req_address, a);
                checkOutput("hold_data", req_wdata, d);
                checkOutput("hold_mask", req_mask, m);
            end
            req_ready = 1'b1;
            @(negedge clock);
            req_ready = 1'b0;
            req_count++;
            err = inject_err && (beat == 0);
            if (w && !err)
                for (int b = 0; b < 4; b++)
                    if (m[b]) mem[(a + 32'(b)) % 512] = d[8*b +: 8];
            dly = (force_delay >= 0) ? force_delay : $urandom_range(0, 2);
            repeat (dly) @(negedge clock);
            resp_data  = {mem[(a + 3) % 512], mem[(a + 2) % 512], mem[(a + 1) % 512], mem[a % 512]};
            resp_error = err;
            resp_valid = 1'b1;
            @(negedge clock);
            resp_valid = 1'b0;
            resp_error = 1'b0;
        end
    end

    // Runs one access and compares against the byte-level model of the rules.
    task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] data, input bit inj, output int cycles);
        int          size, exp_beats, start_count, diffs;
        bit          legal, mis, split, exp_err;
        logic [63:0] v;
        logic [31:0] exp_rd;
        size  = 1 << f3[1:0];
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis   = (int'(addr % 4) + size) > 4;
`ifdef MISALIGNED_SPLIT_EN
        split   = legal && mis;
        exp_err = !legal;
`else
        split   = 1'b0;
        exp_err = !legal || mis;
`endif
        exp_beats = exp_err ? 0 : (inj ? 1 : (split ? 2 : 1));
        if (inj) exp_err = 1'b1;
        v = '0;
        for (int i = 0; i < size; i++) v |= 64'(ref_mem[(addr + 32'(i)) % 512]) << (8 * i);
        if (!st && f3 < 3'd4 && v[8*size-1]) v |= ~((64'd1 << (8 * size)) - 64'd1);
        exp_rd = st ? last_rd : (exp_err ? 32'd0 : v[31:0]);
        if (st && !exp_err)
            for (int i = 0; i < size; i++) ref_mem[(addr + 32'(i)) % 512] = data[8*i +: 8];

        exp_base = addr & ~32'd3; exp_store = st; inject_err = inj; beat_idx = 0;
        start_count = req_count;
        is_store = st; funct3 = f3; source = addr; store_data = data; enable = 1'b1;
        @(negedge clock);
        cycles = 1;
        while (finished !== 1'b1 && cycles < 60) begin
            enable = 1'($urandom); is_store = 1'($urandom); funct3 = 3'($urandom);
            source = $urandom; store_data = $urandom;
            @(negedge clock);
            cycles++;
        end
        enable = 1'b0;
        checkOutput("finished", finished, 1);
        checkOutput("error", error, exp_err);
        checkOutput("new_rd", new_rd, exp_rd);
        checkOutput("beats", req_count - start_count, exp_beats);
        diffs = 0;
        for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) diffs++;
        checkOutput("mem_bytes", diffs, 0);
        last_rd = exp_rd;
        @(negedge clock);
        checkOutput("pulse", finished, 0);
        inject_err = 1'b0;
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 512; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (2) @(negedge clock);
        checkOutput("rst_req_valid", req_valid, 0);
        checkOutput("rst_resp_ready", resp_ready, 0);
        checkOutput("rst_finished", finished, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_new_rd", new_rd, 0);
        clear = 1'b0;
        @(negedge clock);

        force_stall = 0; force_delay = 0;
        setWord(32'h100, 32'h8000_00F0);
        applyStimulus(1'b0, 3'd2, 32'h100, 32'h0, 1'b0, cyc);
        checkOutput("lw_latency", cyc, 3);
        checkOutput("lw_value", new_rd, 32'h8000_00F0);

        setWord(32'h100, 32'h8100_0000);
        applyStimulus(1'b0, 3'd0, 32'h103, 32'h0, 1'b0, cyc);
        checkOutput("lb_value", new_rd, 32'hFFFF_FF81);
        applyStimulus(1'b0, 3'd4, 32'h103, 32'h0, 1'b0, cyc);
        checkOutput("lbu_value", new_rd, 32'h0000_0081);

        force_stall = 3;
        applyStimulus(1'b1, 3'd1, 32'h102, 32'h0000_1234, 1'b0, cyc);
        checkOutput("sh_addr", cap_addr, 32'h100);
        checkOutput("sh_data", cap_data, 32'h1234_0000);
        checkOutput("sh_mask", cap_mask, 4'b1100);
        force_stall = 0;

        setWord(32'h0FC, 32'hBBAA_0000);
        setWord(32'h100, 32'h0000_DDCC);
        applyStimulus(1'b0, 3'd2, 32'h0FE, 32'h0, 1'b0, cyc);
`ifdef MISALIGNED_SPLIT_EN
        checkOutput("split_value", new_rd, 32'hDDCC_BBAA);
        applyStimulus(1'b0, 3'd2, 32'h0FE, 32'h0, 1'b1, cyc);
`else
        checkOutput("nosplit_cycles", cyc, 1);
        applyStimulus(1'b0, 3'd2, 32'h100, 32'h0, 1'b1, cyc);
`endif
        checkOutput("beat0_err_rd", new_rd, 0);

        applyStimulus(1'b0, 3'd3, 32'h100, 32'h0, 1'b0, cyc);
        checkOutput("ld_illegal_cycles", cyc, 1);

        // Clear while waiting for a response; the late response must be ignored.
        setWord(32'h100, 32'h1122_3344);
        force_delay = 3; exp_base = 32'h100; exp_store = 1'b0; beat_idx = 0;
        is_store = 1'b0; funct3 = 3'd2; source = 32'h100; enable = 1'b1;
        @(negedge clock);
        enable = 1'b0;
        cyc = 0;
        while (resp_ready !== 1'b1 && cyc < 20) begin @(negedge clock); cyc++; end
        checkOutput("clr_in_resp0", resp_ready, 1);
        clear = 1'b1;
        @(negedge clock);
        checkOutput("clr_req_valid", req_valid, 0);
        checkOutput("clr_resp_ready", resp_ready, 0);
        checkOutput("clr_finished", finished, 0);
        checkOutput("clr_error", error, 0);
        checkOutput("clr_new_rd", new_rd, 0);
        clear = 1'b0;
        last_rd = '0;
        repeat (6) begin
            @(negedge clock);
            checkOutput("stale_finished", finished, 0);
            checkOutput("stale_req", req_valid, 0);
        end
        checkOutput("stale_rd", new_rd, 0);

        force_stall = -1; force_delay = -1;
        for (int n = 0; n < 80; n++)
            applyStimulus(1'($urandom), 3'($urandom), 32'h0F0 + $urandom_range(0, 32'h5F),
                          $urandom, ($urandom % 10) == 0, cyc);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, tests_failed=%0d", tests_failed);
        $fatal(1);
    end

endmodule
